spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_phase_cnt.sv | 34 +++
 rtl/spi_master.sv | 139 +++++++++++++
 tb/tb_spi_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared state encoding and sizing constants for the SPI master.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_CLK_DIV_DEFAULT = 4;
    localparam int c_BYTE_W          = 8;
    localparam int c_CNT_W           = 8;
    localparam int c_BIT_CNT_W       = 4;

    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(c_BYTE_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_NEXT  = 3'd4,
        S_HOLD  = 3'd5,
        S_CSHI  = 3'd6
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module   : spi_phase_cnt
// Brief    : Loadable down-counter; expired is high once the count reaches 0.
// Revision : 1.0 - initial release
// ============================================================================
module spi_phase_cnt
    import spi_pkg::*;
#(
    parameter int WIDTH = c_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : Byte-streaming SPI mode-0 master with registered bus outputs.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [c_BYTE_W-1:0] tx_data,
    input  logic                tx_valid,
    input  logic                tx_last,
    output logic                tx_ready,
    output logic [c_BYTE_W-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy,
    output logic                sclk,
    output logic                csn,
    output logic                mosi,
    input  logic                miso
);

    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(CLK_DIV - 1);

    spi_state_t             r_state;
    spi_state_t             w_next_state;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_expired;
    logic [c_BYTE_W-1:0]    r_tx_shift;
    logic [c_BYTE_W-1:0]    r_rx_shift;
    logic [c_BIT_CNT_W-1:0] r_bit_cnt;
    logic                   r_last;

    assign w_accept = tx_valid & tx_ready;
    assign w_load   = (w_next_state != r_state);

    spi_phase_cnt #(
        .WIDTH (c_CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (w_load),
        .load_val (c_RELOAD),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:         if (w_accept)  w_next_state = S_SETUP;
            S_SETUP, S_LOW: if (w_expired) w_next_state = S_HIGH;
            S_HIGH: begin
                if (w_expired) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_next_state = r_last ? S_HOLD : S_NEXT;
                    end else begin
                        w_next_state = S_LOW;
                    end
                end
            end
            S_NEXT:         if (w_accept)  w_next_state = S_LOW;
            S_HOLD:         if (w_expired) w_next_state = S_CSHI;
            S_CSHI:         if (w_expired) w_next_state = S_IDLE;
            default:        w_next_state = S_IDLE;
        endcase
    end

    // Every bus output is updated on the edge that enters the new phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csn        <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            tx_ready   <= 1'b0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            rx_data    <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_last     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_ready <= (w_next_state == S_IDLE) || (w_next_state == S_NEXT);
            busy     <= (w_next_state != S_IDLE);

            // The shift register holds the bits still to be sent after the current one.
            if (w_accept) begin
                r_tx_shift <= {tx_data[c_BYTE_W-2:0], 1'b0};
                mosi       <= tx_data[c_BYTE_W-1];
                r_last     <= tx_last;
                r_bit_cnt  <= '0;
            end

            if (w_load) begin
                case (w_next_state)
                    S_SETUP: csn <= 1'b0;
                    S_HIGH: begin
                        sclk       <= 1'b1;
                        r_rx_shift <= {r_rx_shift[c_BYTE_W-2:0], miso};
                        r_bit_cnt  <= r_bit_cnt + c_BIT_CNT_W'(1);
                    end
                    S_LOW: begin
                        sclk <= 1'b0;
                        if (r_state == S_HIGH) begin
                            mosi       <= r_tx_shift[c_BYTE_W-1];
                            r_tx_shift <= {r_tx_shift[c_BYTE_W-2:0], 1'b0};
                        end
                    end
                    S_NEXT, S_HOLD: begin
                        sclk     <= 1'b0;
                        rx_data  <= r_rx_shift;
                        rx_valid <= 1'b1;
                    end
                    S_CSHI: begin
                        csn  <= 1'b1;
                        mosi <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Brief    : Randomized self-checking bench for spi_master (CLK_DIV=2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int CLK2 = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tx_data2  = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_last2  = 1'b0;
    logic       tx_ready2, rx_valid2, busy2, sclk2, csn2, mosi2, miso2;
    logic [7:0] rx_data2;
    logic       miso_tie  = 1'b0;
    assign miso2 = miso_tie ? 1'b1 : mosi2;

    logic [7:0] tx_data1  = 8'h00;
    logic       tx_valid1 = 1'b0;
    logic       tx_last1  = 1'b0;
    logic       tx_ready1, rx_valid1, busy1, sclk1, csn1, mosi1, miso1;
    logic [7:0] rx_data1;
    assign miso1 = mosi1;

    spi_master #(.CLK_DIV(CLK2)) dut2 (
        .clk(clk), .rstn(rstn), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_last(tx_last2), .tx_ready(tx_ready2), .rx_data(rx_data2),
        .rx_valid(rx_valid2), .busy(busy2), .sclk(sclk2), .csn(csn2),
        .mosi(mosi2), .miso(miso2)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rstn(rstn), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_last(tx_last1), .tx_ready(tx_ready1), .rx_data(rx_data1),
        .rx_valid(rx_valid1), .busy(busy1), .sclk(sclk1), .csn(csn1),
        .mosi(mosi1), .miso(miso1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each accepted byte must appear bit-by-bit on mosi at the
    // rising sclk edges, and come back as itself (loopback) or 0xFF (miso tied).
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] mon_cur;
    int   cyc = 0, byte_start = 0, last_rx_cyc = 0, csn_rise_cyc = 0;
    int   bit_idx = 0, hi_cnt = 0;
    logic prev_sclk = 1'b0, prev_csn = 1'b1, acc_prev = 1'b0;
    logic in_cshi = 1'b0, have_rise = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            tx_q.delete();
            rx_q.delete();
            bit_idx   = 0;
            hi_cnt    = 0;
            prev_sclk = 1'b0;
            prev_csn  = 1'b1;
            acc_prev  = 1'b0;
            in_cshi   = 1'b0;
            have_rise = 1'b0;
        end else begin
            if (acc_prev) begin
                check_eq("csn_after_accept", csn2, 0);
                check_eq("sclk_after_accept", sclk2, 0);
                byte_start = cyc;
            end
            if (sclk2 && !prev_sclk) begin
                check_eq("csn_at_sclk_rise", csn2, 0);
                if (tx_q.size() == 0) begin
                    check_eq("sclk_spurious_rise", 1, 0);
                end else begin
                    mon_cur = tx_q[0];
                    check_eq("mosi_bit", mosi2, mon_cur[7 - bit_idx]);
                    bit_idx++;
                    if (bit_idx == 8) begin
                        bit_idx = 0;
                        void'(tx_q.pop_front());
                    end
                end
            end
            if (sclk2) begin
                hi_cnt++;
            end else if (prev_sclk) begin
                check_eq("sclk_high_len", hi_cnt, CLK2);
                hi_cnt = 0;
            end
            if (rx_valid2) begin
                if (rx_q.size() == 0) begin
                    check_eq("rx_valid_spurious", 1, 0);
                end else begin
                    check_eq("rx_data", rx_data2, rx_q.pop_front());
                end
                check_eq("byte_time", cyc - byte_start, 16 * CLK2);
                last_rx_cyc = cyc;
            end
            if (csn2 && !prev_csn) begin
                check_eq("hold_len", cyc - last_rx_cyc, CLK2);
                check_eq("rx_pending_at_csn_rise", rx_q.size(), 0);
                check_eq("bits_pending_at_csn_rise", tx_q.size(), 0);
                check_eq("tx_ready_at_csn_rise", tx_ready2, 0);
                csn_rise_cyc = cyc;
                in_cshi      = 1'b1;
                have_rise    = 1'b1;
            end else if (in_cshi && tx_ready2) begin
                check_eq("cshi_len", cyc - csn_rise_cyc, CLK2);
                check_eq("busy_after_cshi", busy2, 0);
                in_cshi = 1'b0;
            end
            if (!csn2 && prev_csn && have_rise) begin
                check_eq("csn_high_gap_ok", (cyc - csn_rise_cyc) >= CLK2, 1);
            end
            acc_prev = tx_valid2 && tx_ready2;
            if (acc_prev) begin
                tx_q.push_back(tx_data2);
                rx_q.push_back(miso_tie ? 8'hFF : tx_data2);
            end
            prev_sclk = sclk2;
            prev_csn  = csn2;
        end
    end

    logic [7:0] txb [4];

    task automatic wait_ready2();
        int t = 0;
        while (!tx_ready2 && t < 300) begin
            tick();
            t++;
        end
        check_eq("tx_ready_wait", tx_ready2, 1);
    endtask

    task automatic send_txn(input int n, input int stall);
        int bad;
        int t;
        for (int i = 0; i < n; i++) begin
            tx_data2  = txb[i];
            tx_last2  = (i == n - 1);
            tx_valid2 = 1'b1;
            wait_ready2();
            tick();
            // Scramble the inputs while still valid but not ready.
            tx_data2 = 8'($urandom);
            tx_last2 = 1'($urandom);
            tick();
            tick();
            tx_valid2 = 1'b0;
            if (i < n - 1) begin
                wait_ready2();
                bad = 0;
                repeat (stall) begin
                    tick();
                    if (csn2 !== 1'b0 || sclk2 !== 1'b0 || tx_ready2 !== 1'b1) bad++;
                end
                check_eq("next_stall_bus", bad, 0);
            end
        end
        t = 0;
        while (busy2 && t < 300) begin
            tick();
            t++;
        end
        check_eq("txn_done", busy2, 0);
    endtask

    task automatic reset_mid_byte();
        int   rises = 0;
        int   t = 0;
        int   bad = 0;
        logic ps;
        tx_data2  = 8'($urandom);
        tx_last2  = 1'b1;
        tx_valid2 = 1'b1;
        wait_ready2();
        tick();
        tx_valid2 = 1'b0;
        ps = sclk2;
        while (rises < 4 && t < 200) begin
            tick();
            t++;
            if (sclk2 && !ps) rises++;
            ps = sclk2;
        end
        check_eq("rst_reached_high4", rises, 4);
        rstn = 1'b0;
        #1;
        check_eq("rst_mid_csn", csn2, 1);
        check_eq("rst_mid_sclk", sclk2, 0);
        check_eq("rst_mid_busy", busy2, 0);
        check_eq("rst_mid_tx_ready", tx_ready2, 0);
        repeat (3) begin
            tick();
            if (rx_valid2 !== 1'b0) bad++;
        end
        check_eq("rst_mid_no_rx_valid", bad, 0);
        check_eq("rst_mid_rx_data", rx_data2, 8'h00);
        #2 rstn = 1'b1;
        tick();
        check_eq("rst_mid_release_ready", tx_ready2, 1);
    endtask

    task automatic div1_test();
        int   t = 0;
        int   toggles = 0;
        logic ps;
        tx_data1  = 8'h5A;
        tx_last1  = 1'b1;
        tx_valid1 = 1'b1;
        check_eq("d1_ready", tx_ready1, 1);
        tick();
        tx_valid1 = 1'b0;
        tx_data1  = 8'hFF;
        check_eq("d1_csn_low", csn1, 0);
        ps = sclk1;
        while (!rx_valid1 && t < 100) begin
            tick();
            t++;
            if (sclk1 !== ps) toggles++;
            ps = sclk1;
        end
        check_eq("d1_byte_time", t, 16);
        check_eq("d1_sclk_toggles", toggles, 16);
        check_eq("d1_rx_data", rx_data1, 8'h5A);
        t = 0;
        while (busy1 && t < 50) begin
            tick();
            t++;
        end
        check_eq("d1_done", busy1, 0);
        check_eq("d1_csn_idle", csn1, 1);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check_eq("rst_csn", csn2, 1);
        check_eq("rst_sclk", sclk2, 0);
        check_eq("rst_mosi", mosi2, 0);
        check_eq("rst_tx_ready", tx_ready2, 0);
        check_eq("rst_rx_valid", rx_valid2, 0);
        check_eq("rst_busy", busy2, 0);
        check_eq("rst_rx_data", rx_data2, 8'h00);
        check_eq("rst_csn_d1", csn1, 1);
        #2 rstn = 1'b1;
        tick();
        check_eq("release_tx_ready", tx_ready2, 1);
        check_eq("release_tx_ready_d1", tx_ready1, 1);

        txb[0] = 8'hA5;
        send_txn(1, 0);

        txb[0] = 8'h03;
        txb[1] = 8'h1F;
        send_txn(2, 10);

        miso_tie = 1'b1;
        txb[0]   = 8'h00;
        send_txn(1, 0);
        miso_tie = 1'b0;

        reset_mid_byte();
        txb[0] = 8'h3C;
        send_txn(1, 0);

        repeat (12) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) txb[i] = 8'($urandom);
            miso_tie = ($urandom_range(0, 3) == 0);
            send_txn(n, $urandom_range(0, 6));
        end
        miso_tie = 1'b0;
        repeat (4) tick();
        check_eq("rx_queue_drained", rx_q.size(), 0);

        div1_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
